// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - Operation codes, cycle counts and divide helper for the multiply/divide unit.
package md_pkg;

  localparam int MD_OP_W = 4;
  localparam int CNT_W   = 4;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  localparam logic [MD_OP_W-1:0] MD_NONE = 4'd0;
  localparam logic [MD_OP_W-1:0] MULT    = 4'd1;
  localparam logic [MD_OP_W-1:0] MULTU   = 4'd2;
  localparam logic [MD_OP_W-1:0] DIV     = 4'd3;
  localparam logic [MD_OP_W-1:0] DIVU    = 4'd4;
  localparam logic [MD_OP_W-1:0] MFHI    = 4'd5;
  localparam logic [MD_OP_W-1:0] MFLO    = 4'd6;
  localparam logic [MD_OP_W-1:0] MTHI    = 4'd7;
  localparam logic [MD_OP_W-1:0] MTLO    = 4'd8;

  // Returns {remainder, quotient}. Works on magnitudes so that the
  // most-negative dividend divided by -1 wraps instead of overflowing.
  function automatic logic [63:0] md_divide(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        is_signed);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    if (mag_b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = mag_a / mag_b;
      r = mag_a % mag_b;
    end
    if (neg_a ^ neg_b) q = ~q + 32'd1;
    if (neg_a)         r = ~r + 32'd1;
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - E-stage to multiply/divide unit signal bundle.
interface mult_div_unit_if;
  import md_pkg::*;

  logic               start;
  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        A;
  logic [31:0]        B;
  logic               busy;
  logic               stall_req;
  logic [31:0]        HI;
  logic [31:0]        LO;
  logic [31:0]        rd_data;

  modport master (
    output start, md_op, A, B,
    input  busy, stall_req, HI, LO, rd_data
  );

  modport slave (
    input  start, md_op, A, B,
    output busy, stall_req, HI, LO, rd_data
  );

endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - Multi-cycle MULT/DIV unit owning HI/LO; drives the pipeline stall request.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   md
);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] div_res;

  always_comb begin
    a_sx    = {{32{md.A[31]}}, md.A};
    b_sx    = {{32{md.B[31]}}, md.B};
    prod_s  = a_sx * b_sx;
    prod_u  = {32'd0, md.A} * {32'd0, md.B};
    div_res = md_divide(md.A, md.B, md.md_op == DIV);
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;

    if (busy_q) begin
      // New starts and HI/LO moves are dropped while an operation is in flight.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
      end
    end else if (md.start) begin
      case (md.md_op)
        MULT, MULTU: begin
          {pend_hi_d, pend_lo_d} = (md.md_op == MULT) ? prod_s : prod_u;
          cnt_d  = CNT_W'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        DIV, DIVU: begin
          // A zero divisor commits the current HI/LO back unchanged.
          if (md.B == 32'd0) begin
            pend_hi_d = hi_q;
            pend_lo_d = lo_q;
          end else begin
            {pend_hi_d, pend_lo_d} = div_res;
          end
          cnt_d  = CNT_W'(DIV_CYCLES);
          busy_d = 1'b1;
        end
        default: ;
      endcase
    end else begin
      case (md.md_op)
        MTHI:    hi_d = md.A;
        MTLO:    lo_d = md.A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign md.busy      = busy_q;
  assign md.stall_req = busy_q | md.start;
  assign md.HI        = hi_q;
  assign md.LO        = lo_q;
  assign md.rd_data   = (md.md_op == MFHI) ? hi_q :
                        (md.md_op == MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - Randomized self-checking bench for mult_div_unit against a behavioural model.
module tb_mult_div_unit;
  import md_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if bif ();

  mult_div_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bif.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: results computed with wide arithmetic, commit scheduled by edge number.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_active;
  longint      m_edge, m_commit_edge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, m_edge);
  endtask

  always @(posedge clk) begin
    logic [63:0] up;
    longint      sa, sb, sq, sr;
    m_edge++;
    if (reset) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_edge == m_commit_edge) begin
        m_hi = m_phi;
        m_lo = m_plo;
        m_active = 1'b0;
      end
    end else if (bif.start && bif.md_op inside {MULT, MULTU, DIV, DIVU}) begin
      sa = longint'($signed(bif.A));
      sb = longint'($signed(bif.B));
      m_active = 1'b1;
      case (bif.md_op)
        MULT: begin
          sq = sa * sb;
          {m_phi, m_plo} = sq;
          m_commit_edge = m_edge + NM;
        end
        MULTU: begin
          up = {32'd0, bif.A} * {32'd0, bif.B};
          {m_phi, m_plo} = up;
          m_commit_edge = m_edge + NM;
        end
        default: begin
          m_commit_edge = m_edge + ND;
          if (bif.B == 32'd0) begin
            m_phi = m_hi;
            m_plo = m_lo;
          end else if (bif.md_op == DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            m_plo = sq[31:0];
            m_phi = sr[31:0];
          end else begin
            m_plo = bif.A / bif.B;
            m_phi = bif.A % bif.B;
          end
        end
      endcase
    end else if (!bif.start && bif.md_op == MTHI) begin
      m_hi = bif.A;
    end else if (!bif.start && bif.md_op == MTLO) begin
      m_lo = bif.A;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      {31'd0, bif.busy},      {31'd0, m_active});
      chk("stall_req", {31'd0, bif.stall_req}, {31'd0, m_active | bif.start});
      chk("HI",        bif.HI, m_hi);
      chk("LO",        bif.LO, m_lo);
      chk("rd_data",   bif.rd_data,
          (bif.md_op == MFHI) ? m_hi : (bif.md_op == MFLO) ? m_lo : 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bif.start = op inside {MULT, MULTU, DIV, DIVU};
    bif.md_op = op;
    bif.A     = a;
    bif.B     = b;
    step(1);
    bif.start = 1'b0;
    bif.md_op = MD_NONE;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_edge = 0;
    m_commit_edge = 0;
    m_active = 1'b0;
    reset = 1'b1;
    bif.start = 1'b0;
    bif.md_op = MD_NONE;
    bif.A = 32'd0;
    bif.B = 32'd0;
    step(2);
    chk_en = 1'b1;
    chk("reset_HI", bif.HI, 32'd0);
    chk("reset_busy", {31'd0, bif.busy}, 32'd0);
    reset = 1'b0;
    step(1);

    do_op(MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy_first", {31'd0, bif.busy}, 32'd1);
    step(4);
    chk("mult_busy_last", {31'd0, bif.busy}, 32'd1);
    step(1);
    chk("mult_done", {31'd0, bif.busy}, 32'd0);
    chk("mult_HI", bif.HI, 32'hFFFF_FFFF);
    chk("mult_LO", bif.LO, 32'hFFFF_FFFA);
    chk("model_mult_LO", m_lo, 32'hFFFF_FFFA);

    do_op(DIVU, 32'd100, 32'd7);
    step(9);
    chk("divu_busy_last", {31'd0, bif.busy}, 32'd1);
    step(1);
    chk("divu_LO", bif.LO, 32'd14);
    chk("divu_HI", bif.HI, 32'd2);

    do_op(DIV, 32'hFFFF_FFF9, 32'd2);
    step(10);
    chk("div_LO", bif.LO, 32'hFFFF_FFFD);
    chk("div_HI", bif.HI, 32'hFFFF_FFFF);
    chk("model_div_HI", m_hi, 32'hFFFF_FFFF);

    do_op(MTHI, 32'h1234, 32'd0);
    chk("mthi_HI", bif.HI, 32'h1234);
    do_op(DIV, 32'd5, 32'd0);
    step(9);
    chk("div0_busy_last", {31'd0, bif.busy}, 32'd1);
    step(1);
    chk("div0_HI", bif.HI, 32'h1234);
    chk("div0_LO", bif.LO, 32'hFFFF_FFFD);

    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1);
    do_op(MULT, 32'd7, 32'd9);
    step(3);
    chk("multu_HI", bif.HI, 32'hFFFF_FFFE);
    chk("multu_LO", bif.LO, 32'h0000_0001);
    step(6);
    chk("ignored_start_LO", bif.LO, 32'h0000_0001);

    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    step(10);
    chk("divovf_LO", bif.LO, 32'h8000_0000);
    chk("divovf_HI", bif.HI, 32'd0);

    do_op(DIV, 32'd50, 32'd3);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_busy", {31'd0, bif.busy}, 32'd0);
    chk("rst_LO", bif.LO, 32'd0);
    step(10);
    chk("rst_no_commit_LO", bif.LO, 32'd0);

    do_op(MULT, 32'd3, 32'd4);
    do_op(MTLO, 32'hDEAD, 32'd0);
    step(4);
    chk("mtlo_busy_LO", bif.LO, 32'd12);
    bif.md_op = MFLO;
    #1;
    chk("mflo_rd", bif.rd_data, 32'd12);
    bif.md_op = 4'hF;
    #1;
    chk("bad_op_rd", bif.rd_data, 32'd0);
    step(1);
    chk("bad_op_LO", bif.LO, 32'd12);
    bif.md_op = MD_NONE;

    for (int i = 0; i < 250; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 11))
        0, 1:    op = MULT;
        2:       op = MULTU;
        3, 4:    op = DIV;
        5:       op = DIVU;
        6:       op = MTHI;
        7:       op = MTLO;
        8:       op = MFHI;
        9:       op = MFLO;
        10:      op = 4'($urandom_range(9, 15));
        default: op = MD_NONE;
      endcase
      do_op(op, pick32(), pick32());
      for (int j = 0; j < int'($urandom_range(0, 12)); j++) begin
        if ($urandom_range(0, 9) == 0) begin
          do_op(4'($urandom_range(1, 8)), pick32(), pick32());
        end else begin
          bif.md_op = 4'($urandom_range(0, 15));
          bif.A = pick32();
          reset = ($urandom_range(0, 80) == 0);
          step(1);
          reset = 1'b0;
          bif.md_op = MD_NONE;
        end
      end
    end
    step(12);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
